// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle fetch/decode/execute/writeback control FSM
// Owns the program counter and instruction register; strobes decode directly from state.
module fetch_sequencer #(
  parameter int          PC_W    = 5,
  parameter logic [7:0]  HALT_OP = 8'hFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [31:0]     inst,
  input  logic            dec_w_r,
  input  logic            dec_rst,
  input  logic            dec_pc_inc,
  input  logic            dec_jmp,
  input  logic [4:0]      dec_jmp_add,
  output logic            alu_en,
  output logic            rf_we,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [2:0]      state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [PC_W-1:0] jmp_tgt;

  // Jump target is 5 bits wide; fit it to the pc width.
  generate
    if (PC_W > 5) begin : g_jmp_ext
      assign jmp_tgt = {{(PC_W-5){1'b0}}, dec_jmp_add};
    end else if (PC_W == 5) begin : g_jmp_eq
      assign jmp_tgt = dec_jmp_add;
    end else begin : g_jmp_trunc
      assign jmp_tgt = dec_jmp_add[PC_W-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (inst_q[31:24] == HALT_OP) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        if (dec_rst) begin
          pc_d    = '0;
          inst_d  = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        if (dec_jmp)         pc_d = jmp_tgt;
        else if (dec_pc_inc) pc_d = pc_q + PC_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign state     = state_q;
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign inst      = inst_q;
  assign imem_req  = (state_q == S_FETCH);
  assign alu_en    = (state_q == S_EXECUTE);
  assign rf_we     = (state_q == S_WRITEBACK) && dec_w_r;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized instruction-level checks
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_sequencer;
  localparam int PC_W = 5;

  logic            clk = 1'b0;
  logic            rst, run, imem_ack;
  logic [31:0]     imem_data;
  logic            dec_w_r, dec_rst, dec_pc_inc, dec_jmp;
  logic [4:0]      dec_jmp_add;
  logic            imem_req, alu_en, rf_we, busy, halted;
  logic [PC_W-1:0] imem_addr, pc;
  logic [31:0]     inst;
  logic [2:0]      state;

  int n_tests = 0;
  int n_fail  = 0;
  int m_pc;
  logic [31:0] m_inst;

  fetch_sequencer #(.PC_W(PC_W), .HALT_OP(8'hFF)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst(inst), .dec_w_r(dec_w_r), .dec_rst(dec_rst), .dec_pc_inc(dec_pc_inc),
    .dec_jmp(dec_jmp), .dec_jmp_add(dec_jmp_add), .alu_en(alu_en), .rf_we(rf_we),
    .pc(pc), .busy(busy), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic noise_dec();
    dec_w_r     = 1'($urandom);
    dec_rst     = 1'($urandom);
    dec_pc_inc  = 1'($urandom);
    dec_jmp     = 1'($urandom);
    dec_jmp_add = 5'($urandom);
  endtask

  task automatic reset_dut();
    rst = 1'b1; run = 1'($urandom); imem_ack = 1'($urandom); imem_data = $urandom;
    noise_dec();
    tick(); tick();
    rst = 1'b0; run = 1'b0; imem_ack = 1'b0;
    m_pc = 0; m_inst = 32'h0;
    check("rst_state", state, 0);
    check("rst_pc", pc, 0);
    check("rst_inst", inst, 0);
    check("rst_req", imem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_strobes", {alu_en, rf_we}, 0);
  endtask

  // From IDLE: raise run, with a stray ack that must be ignored.
  task automatic go_fetch();
    run = 1'b1; imem_ack = 1'($urandom); imem_data = $urandom;
    tick();
    check("go_state", state, 1);
    check("go_busy", busy, 1);
  endtask

  // One full instruction, entered with the DUT sitting in FETCH.
  task automatic do_instr(input logic [31:0] data, input int stall, input logic w_r,
                          input logic jmp, input logic inc, input logic drst,
                          input logic run_after, input logic [4:0] jadd);
    int cyc = 0;
    check("f_req", imem_req, 1);
    check("f_addr", imem_addr, m_pc);
    check("f_inst", inst, m_inst);
    for (int k = 0; k < stall; k++) begin
      imem_ack = 1'b0; imem_data = $urandom; run = 1'($urandom); noise_dec();
      tick(); cyc++;
      check("stall_req", imem_req, 1);
      check("stall_addr", imem_addr, m_pc);
      check("stall_inst", inst, m_inst);
    end
    imem_ack = 1'b1; imem_data = data; noise_dec();
    tick(); cyc++;
    m_inst = data;
    check("d_inst", inst, m_inst);
    check("d_state", state, 2);
    check("d_strobes", {imem_req, alu_en, rf_we}, 0);
    imem_ack = 1'($urandom); imem_data = $urandom; noise_dec();
    if (data[31:24] == 8'hFF) begin
      run = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("h_state", state, 5);
        check("h_halted", halted, 1);
        check("h_busy", busy, 0);
        check("h_strobes", {alu_en, rf_we, imem_req}, 0);
        check("h_pc", pc, m_pc);
      end
      return;
    end
    tick(); cyc++;
    check("e_state", state, 3);
    check("e_alu", alu_en, 1);
    check("e_rf", rf_we, 0);
    dec_rst = drst; dec_w_r = w_r; dec_jmp = jmp; dec_pc_inc = inc; dec_jmp_add = jadd;
    run = run_after; imem_ack = 1'($urandom); imem_data = $urandom;
    tick(); cyc++;
    if (drst) begin
      m_pc = 0; m_inst = 32'h0;
      check("x_state", state, 0);
      check("x_pc", pc, 0);
      check("x_inst", inst, 0);
      check("x_strobes", {alu_en, rf_we}, 0);
      return;
    end
    check("w_state", state, 4);
    check("w_rf", rf_we, w_r);
    check("w_alu", alu_en, 0);
    tick(); cyc++;
    if (jmp)      m_pc = int'(jadd) % (1 << PC_W);
    else if (inc) m_pc = (m_pc + 1) % (1 << PC_W);
    check("n_pc", pc, m_pc);
    check("n_addr", imem_addr, m_pc);
    check("n_inst", inst, m_inst);
    check("n_state", state, run_after ? 1 : 0);
    if (run_after) check("instr_cycles", cyc, 4 + stall);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] d = $urandom;
    if (d[31:24] == 8'hFF) d[31:24] = 8'h00;
    return d;
  endfunction

  initial begin
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = '0;
    dec_w_r = 0; dec_rst = 0; dec_pc_inc = 0; dec_jmp = 0; dec_jmp_add = '0;
    tick();
    reset_dut();

    // IDLE ignores ack while run is low
    imem_ack = 1'b1; imem_data = 32'hDEADBEEF;
    tick();
    check("idle_state", state, 0);
    check("idle_inst", inst, 0);

    go_fetch();
    do_instr(32'h07000101, 0, 1, 0, 1, 0, 1, 5'd0);
    do_instr(rand_op(), 3, 0, 0, 1, 0, 1, 5'd0);
    do_instr(rand_op(), 1, 1, 0, 1, 0, 1, 5'd0);
    check("pc_is_3", pc, 3);
    do_instr(rand_op(), 0, 0, 1, 1, 0, 1, 5'd20);
    check("jump_pc", imem_addr, 20);
    do_instr(rand_op(), 0, 1, 1, 0, 0, 1, 5'd31);
    do_instr(rand_op(), 0, 1, 0, 1, 0, 1, 5'd0);
    check("wrap_pc", pc, 0);
    do_instr(rand_op(), 2, 0, 0, 0, 0, 1, 5'd9);
    do_instr(rand_op(), 0, 1, 0, 1, 0, 0, 5'd0);
    go_fetch();
    do_instr(rand_op(), 0, 1, 1, 1, 1, 1, 5'd17);
    go_fetch();
    do_instr(32'hFF000000, 0, 1, 0, 1, 0, 1, 5'd0);
    reset_dut();

    // Reset mid-FETCH: the pending fetch is dropped and a late ack ignored
    go_fetch();
    do_instr(32'h12345678, 0, 1, 0, 1, 0, 1, 5'd0);
    rst = 1'b1; imem_ack = 1'b1; imem_data = 32'hCAFEF00D;
    tick();
    rst = 1'b0; run = 1'b0;
    tick();
    m_pc = 0; m_inst = 32'h0;
    check("rf_state", state, 0);
    check("rf_inst", inst, 0);
    check("rf_pc", pc, 0);
    check("rf_req", imem_req, 0);
    imem_ack = 1'b0;

    go_fetch();
    for (int i = 0; i < 80; i++) begin
      logic [31:0] d;
      logic        ra;
      d = ($urandom_range(0, 11) == 0) ? {8'hFF, 24'($urandom)} : rand_op();
      ra = ($urandom_range(0, 3) != 0);
      do_instr(d, $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 9) == 0), ra, 5'($urandom));
      if (state == 3'd5) begin
        reset_dut();
        go_fetch();
      end else if (state == 3'd0) begin
        run = 1'b0;
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          imem_ack = 1'($urandom); imem_data = $urandom;
          tick();
          check("r_idle", state, 0);
          check("r_idle_inst", inst, m_inst);
        end
        go_fetch();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
